// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial operand transmitter and its comparator.
// State encodings and the counter width helper live here.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        st_idle  = 2'b00,
        st_clear = 2'b01,
        st_shift = 2'b10
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_operand_transmitter_msb_first_piso.sv
// Parallel-in serial-out shift register, MSB leaves first.
// Load takes priority so a new word can replace the finishing one.
module piso_shift_reg_msb_first #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign q_msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_operand_transmitter_msb_first.sv
// Handshaked operand pair in, comparator clear then MSB-first bit pairs out.
// FSM, bit counter and handshake; two PISO registers hold the operands.
module serial_operand_transmitter_msb_first
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             cmp_rst,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic             in_shift;
    logic             at_last;
    logic             accept;
    logic             sr_load;
    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;
    logic             a_msb;
    logic             b_msb;

    assign in_shift = (state_q == st_shift);
    assign at_last  = in_shift && (cnt_q == '0);
    assign in_ready = !rst && ((state_q == st_idle) || at_last);
    assign accept   = in_valid && in_ready;

    // Reset reuses the load path to zero the operand registers.
    assign sr_load = rst || accept;
    assign a_load  = rst ? '0 : in_a;
    assign b_load  = rst ? '0 : in_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = st_idle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                st_idle: begin
                    if (accept) begin
                        state_d = st_clear;
                    end
                end
                st_clear: begin
                    cnt_d   = CNT_LOAD;
                    state_d = st_shift;
                end
                st_shift: begin
                    if (cnt_q == '0) begin
                        state_d = accept ? st_clear : st_idle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = st_idle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    piso_shift_reg_msb_first #(.WIDTH(WIDTH)) u_sr_a (
        .clk   (clk),
        .load  (sr_load),
        .shift (in_shift),
        .d     (a_load),
        .q_msb (a_msb)
    );

    piso_shift_reg_msb_first #(.WIDTH(WIDTH)) u_sr_b (
        .clk   (clk),
        .load  (sr_load),
        .shift (in_shift),
        .d     (b_load),
        .q_msb (b_msb)
    );

    assign ser_valid = in_shift;
    assign ser_last  = at_last;
    assign ser_a     = in_shift && a_msb;
    assign ser_b     = in_shift && b_msb;
    assign busy      = (state_q != st_idle);
    assign cmp_rst   = rst || (state_q == st_clear);

endmodule
